// File: rtl/rom_adder_arbiter.sv
// rom_adder_arbiter: round-robin share of one registered ROM adder between NUM_REQ requesters
module rom_adder_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int OP_WIDTH   = 4,
  parameter int DATA_WIDTH = 5,
  parameter int ID_WIDTH   = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*OP_WIDTH-1:0]  req_a_i,
  input  logic [NUM_REQ*OP_WIDTH-1:0]  req_b_i,
  output logic [OP_WIDTH-1:0]          adder_a_o,
  output logic [OP_WIDTH-1:0]          adder_b_o,
  input  logic [DATA_WIDTH-1:0]        adder_sum_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [ID_WIDTH-1:0]          rsp_id_o,
  output logic [DATA_WIDTH-1:0]        rsp_sum_o
);
  logic                s1_valid;
  logic [ID_WIDTH-1:0] s1_id, last_grant, hi_id, lo_id, winner;
  logic                hi_found, lo_found, out_free, s1_adv, issue_en, grant;
  logic [OP_WIDTH-1:0] a_q, b_q;
  logic [OP_WIDTH-1:0] a_arr [NUM_REQ];
  logic [OP_WIDTH-1:0] b_arr [NUM_REQ];
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign a_arr[k] = req_a_i[k*OP_WIDTH +: OP_WIDTH];
    assign b_arr[k] = req_b_i[k*OP_WIDTH +: OP_WIDTH];
  end
  assign out_free = !rsp_valid_o || rsp_ready_i;
  assign s1_adv   = s1_valid && out_free;
  assign issue_en = !s1_valid || out_free;
  // Lowest valid index above the pointer wins; otherwise wrap to the lowest valid overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k] && ID_WIDTH'(k) > last_grant) begin
        hi_found = 1'b1;
        hi_id    = ID_WIDTH'(k);
      end
      if (req_valid_i[k]) begin
        lo_found = 1'b1;
        lo_id    = ID_WIDTH'(k);
      end
    end
  end
  assign winner      = hi_found ? hi_id : lo_id;
  assign grant       = !rst_i && issue_en && lo_found;
  assign req_ready_o = grant ? NUM_REQ'(1) << winner : '0;
  // Holding the last operands keeps the ROM address, and so adder_sum_i, stable across stalls.
  assign adder_a_o   = grant ? a_arr[winner] : a_q;
  assign adder_b_o   = grant ? b_arr[winner] : b_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid    <= 1'b0;
      s1_id       <= '0;
      last_grant  <= ID_WIDTH'(NUM_REQ - 1);
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_sum_o   <= '0;
    end else begin
      if (grant) begin
        s1_valid   <= 1'b1;
        s1_id      <= winner;
        last_grant <= winner;
        a_q        <= a_arr[winner];
        b_q        <= b_arr[winner];
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        rsp_valid_o <= 1'b1;
        rsp_sum_o   <= adder_sum_i;
        rsp_id_o    <= s1_id;
      end else if (rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end
endmodule
